// File: rtl/nios_loader_pkg.sv
// Shared types and widths for the on-chip memory stream loader.
package nios_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PACK  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int LANES      = 4;
  localparam int LANE_W     = 2;
  localparam int BYTE_CNT_W = 16;

endpackage

// File: rtl/nios_st_byte_packer.sv
// Packs stream bytes little-endian into a 32-bit word with per-lane byte enables.
module nios_st_byte_packer
  import nios_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        load,
  input  logic        sop,
  input  logic        eop,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic [3:0]  be,
  output logic        eop_seen,
  output logic        flush
);

  logic [LANE_W-1:0] lane_q, lane_d, lane_sel;
  logic [31:0]       word_q, word_d;
  logic [3:0]        be_q, be_d;
  logic              eop_q, eop_d;

  // A startofpacket byte always lands in lane 0, discarding any partial word.
  assign lane_sel = sop ? '0 : lane_q;
  assign flush    = eop | (~sop & (lane_q == LANE_W'(LANES - 1)));

  always_comb begin
    lane_d = lane_q;
    word_d = word_q;
    be_d   = be_q;
    eop_d  = eop_q;
    if (clear) begin
      lane_d = '0;
      word_d = '0;
      be_d   = '0;
      eop_d  = 1'b0;
    end else if (load) begin
      if (sop) begin
        word_d = '0;
        be_d   = '0;
      end
      word_d[{lane_sel, 3'b000} +: 8] = data;
      be_d[lane_sel]                  = 1'b1;
      lane_d                          = lane_sel + LANE_W'(1);
      eop_d                           = eop;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lane_q <= '0;
      word_q <= '0;
      be_q   <= '0;
      eop_q  <= 1'b0;
    end else begin
      lane_q <= lane_d;
      word_q <= word_d;
      be_q   <= be_d;
      eop_q  <= eop_d;
    end
  end

  assign word     = word_q;
  assign be       = be_q;
  assign eop_seen = eop_q;

endmodule

// File: rtl/nios_onchip_mem_loader.sv
// Avalon-ST byte stream to Avalon-MM word writer for the Nios on-chip memory.
module nios_onchip_mem_loader
  import nios_loader_pkg::*;
#(
  parameter int ADDR_W      = 14,
  parameter int BASE_WORD   = 0,
  parameter int DEPTH_WORDS = 16384
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            st_data,
  input  logic                  st_valid,
  input  logic                  st_startofpacket,
  input  logic                  st_endofpacket,
  output logic                  st_ready,
  output logic [ADDR_W-1:0]     m_address,
  output logic [3:0]            m_byteenable,
  output logic                  m_chipselect,
  output logic                  m_write,
  output logic [31:0]           m_writedata,
  input  logic                  m_waitrequest,
  output logic                  done,
  output logic [BYTE_CNT_W-1:0] byte_count,
  output logic                  overflow,
  output logic                  pkt_err
);

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [BYTE_CNT_W-1:0]   cnt_q, cnt_d;
  logic [BYTE_CNT_W-1:0]   bc_q, bc_d;
  logic                    ovf_q, ovf_d;
  logic                    err_q, err_d;
  logic                    pk_load, pk_clear, pk_flush, pk_eop;
  logic                    accept;

  nios_st_byte_packer u_packer (
    .clk      (clk),
    .reset    (reset),
    .clear    (pk_clear),
    .load     (pk_load),
    .sop      (st_startofpacket),
    .eop      (st_endofpacket),
    .data     (st_data),
    .word     (m_writedata),
    .be       (m_byteenable),
    .eop_seen (pk_eop),
    .flush    (pk_flush)
  );

  // Handshake outputs are gated by reset so a write in flight drops immediately.
  assign st_ready     = ~reset & ((state_q == IDLE) | (state_q == PACK));
  assign m_write      = ~reset & (state_q == WRITE);
  assign m_chipselect = m_write;
  assign done         = ~reset & (state_q == DONE);
  assign accept       = st_valid & st_ready;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    bc_d     = bc_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    pk_load  = 1'b0;
    pk_clear = 1'b0;
    case (state_q)
      IDLE, PACK: begin
        if (accept && (st_startofpacket || state_q == PACK)) begin
          pk_load = 1'b1;
          if (st_startofpacket) begin
            addr_d = ADDR_W'(BASE_WORD);
            cnt_d  = BYTE_CNT_W'(1);
            ovf_d  = 1'b0;
            err_d  = (state_q == PACK);
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + BYTE_CNT_W'(1);
          end
          state_d = pk_flush ? WRITE : PACK;
        end
      end
      WRITE: begin
        if (!m_waitrequest) begin
          pk_clear = 1'b1;
          if (addr_q == ADDR_W'(DEPTH_WORDS - 1)) begin
            addr_d = '0;
            ovf_d  = 1'b1;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
          if (pk_eop) begin
            bc_d    = cnt_q;
            state_d = DONE;
          end else begin
            state_d = PACK;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      bc_q    <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      bc_q    <= bc_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  assign m_address  = addr_q;
  assign byte_count = bc_q;
  assign overflow   = ovf_q;
  assign pkt_err    = err_q;

endmodule

// File: tb/tb_nios_onchip_mem_loader.sv
// Scoreboard bench: one loader at base 0 and one at the top word share the stream.
module tb_nios_onchip_mem_loader;

  typedef struct packed {
    logic [13:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } wr_t;

  typedef struct packed {
    logic [15:0] cnt;
    logic        ovf;
    logic        err;
  } dn_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  st_data;
  logic        st_valid, st_sop, st_eop;
  logic        m_waitrequest;

  logic        st_ready, m_cs, m_write, done, overflow, pkt_err;
  logic [13:0] m_address;
  logic [3:0]  m_be;
  logic [31:0] m_wdata;
  logic [15:0] byte_count;

  logic        w_st_ready, w_cs, w_write, w_done, w_overflow, w_pkt_err;
  logic [13:0] w_address;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [15:0] w_byte_count;

  int n_tests = 0;
  int n_fail  = 0;
  int stall_cnt = 0;
  int wr_cnt = 0;

  wr_t wq0[$], wq1[$];
  dn_t dq0[$], dq1[$];

  logic        in_pkt[2];
  int          lane_m[2];
  int          cnt_m[2];
  logic [31:0] word_m[2];
  logic [3:0]  be_m[2];
  logic [13:0] addr_m[2];
  logic        ovf_m[2], err_m[2];

  always #5 clk = ~clk;

  nios_onchip_mem_loader #(.ADDR_W(14), .BASE_WORD(0), .DEPTH_WORDS(16384)) u_dut (
    .clk(clk), .reset(reset), .st_data(st_data), .st_valid(st_valid),
    .st_startofpacket(st_sop), .st_endofpacket(st_eop), .st_ready(st_ready),
    .m_address(m_address), .m_byteenable(m_be), .m_chipselect(m_cs),
    .m_write(m_write), .m_writedata(m_wdata), .m_waitrequest(m_waitrequest),
    .done(done), .byte_count(byte_count), .overflow(overflow), .pkt_err(pkt_err)
  );

  nios_onchip_mem_loader #(.ADDR_W(14), .BASE_WORD(16383), .DEPTH_WORDS(16384)) u_wrap (
    .clk(clk), .reset(reset), .st_data(st_data), .st_valid(st_valid),
    .st_startofpacket(st_sop), .st_endofpacket(st_eop), .st_ready(w_st_ready),
    .m_address(w_address), .m_byteenable(w_be), .m_chipselect(w_cs),
    .m_write(w_write), .m_writedata(w_wdata), .m_waitrequest(m_waitrequest),
    .done(w_done), .byte_count(w_byte_count), .overflow(w_overflow), .pkt_err(w_pkt_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      in_pkt[i] = 1'b0;
      lane_m[i] = 0;
      cnt_m[i]  = 0;
      word_m[i] = '0;
      be_m[i]   = '0;
      addr_m[i] = '0;
      ovf_m[i]  = 1'b0;
      err_m[i]  = 1'b0;
    end
    wq0.delete(); wq1.delete(); dq0.delete(); dq1.delete();
  endtask

  // Reference behaviour for one accepted byte, applied to both bases.
  task automatic model_accept(input logic [7:0] d, input logic s, input logic e);
    for (int i = 0; i < 2; i++) begin
      logic [31:0] w;
      logic [3:0]  b;
      wr_t wr;
      dn_t dn;
      if (s) begin
        err_m[i]  = in_pkt[i];
        ovf_m[i]  = 1'b0;
        in_pkt[i] = 1'b1;
        lane_m[i] = 0;
        word_m[i] = '0;
        be_m[i]   = '0;
        addr_m[i] = (i == 0) ? 14'd0 : 14'd16383;
        cnt_m[i]  = 0;
      end
      if (in_pkt[i]) begin
        w = word_m[i];
        b = be_m[i];
        w[lane_m[i]*8 +: 8] = d;
        b[lane_m[i]] = 1'b1;
        word_m[i] = w;
        be_m[i]   = b;
        if (cnt_m[i] < 65535) cnt_m[i]++;
        if (lane_m[i] == 3 || e) begin
          wr.a = addr_m[i]; wr.d = w; wr.be = b;
          if (i == 0) wq0.push_back(wr); else wq1.push_back(wr);
          if (addr_m[i] == 14'd16383) begin
            addr_m[i] = '0;
            ovf_m[i]  = 1'b1;
          end else begin
            addr_m[i] = addr_m[i] + 14'd1;
          end
          lane_m[i] = 0;
          word_m[i] = '0;
          be_m[i]   = '0;
          if (e) begin
            dn.cnt = cnt_m[i][15:0]; dn.ovf = ovf_m[i]; dn.err = err_m[i];
            if (i == 0) dq0.push_back(dn); else dq1.push_back(dn);
            in_pkt[i] = 1'b0;
          end
        end else begin
          lane_m[i]++;
        end
      end
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_byte(input logic [7:0] d, input logic s, input logic e);
    bit got = 0;
    st_data = d; st_sop = s; st_eop = e; st_valid = 1'b1;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (st_ready) begin
        got = 1;
        model_accept(d, s, e);
      end
      @(posedge clk); #1;
    end
    check("byte_accept", got, 1);
    st_valid = 1'b0; st_sop = 1'b0; st_eop = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] start, input int len, input logic with_eop);
    for (int i = 0; i < len; i++)
      send_byte(start + 8'(i), i == 0, with_eop && (i == len - 1));
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 60; k++) begin
      if (wq0.size() == 0 && wq1.size() == 0 && dq0.size() == 0 && dq1.size() == 0) break;
      @(negedge clk);
    end
    check("drain", wq0.size() + wq1.size() + dq0.size() + dq1.size(), 0);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (m_write) begin
        check("rdy_in_wr", st_ready, 0);
        check("cs", m_cs, 1);
        check("wq_depth", wq0.size(), 1);
        if (wq0.size() > 0) begin
          check("wr_addr", m_address, wq0[0].a);
          check("wr_data", m_wdata, wq0[0].d);
          check("wr_be", m_be, wq0[0].be);
          if (m_waitrequest) stall_cnt++;
          else begin
            void'(wq0.pop_front());
            wr_cnt++;
          end
        end
      end
      if (done) begin
        check("dq_depth", dq0.size(), 1);
        if (dq0.size() > 0) begin
          check("byte_count", byte_count, dq0[0].cnt);
          check("overflow", overflow, dq0[0].ovf);
          check("pkt_err", pkt_err, dq0[0].err);
          void'(dq0.pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (w_write) begin
        check("w_cs", w_cs, 1);
        check("w_wq_depth", wq1.size(), 1);
        if (wq1.size() > 0) begin
          check("w_wr_addr", w_address, wq1[0].a);
          check("w_wr_data", w_wdata, wq1[0].d);
          check("w_wr_be", w_be, wq1[0].be);
          if (!m_waitrequest) void'(wq1.pop_front());
        end
      end
      if (w_done) begin
        check("w_dq_depth", dq1.size(), 1);
        if (dq1.size() > 0) begin
          check("w_byte_count", w_byte_count, dq1[0].cnt);
          check("w_overflow", w_overflow, dq1[0].ovf);
          check("w_pkt_err", w_pkt_err, dq1[0].err);
          void'(dq1.pop_front());
        end
      end
    end
  end

  initial begin
    reset = 1'b1; st_data = '0; st_valid = 1'b0; st_sop = 1'b0; st_eop = 1'b0;
    m_waitrequest = 1'b0;
    model_reset();
    @(negedge clk);
    check("rst_ready", st_ready, 0);
    check("rst_write", m_write, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", st_ready, 1);
    check("post_rst_done", done, 0);
    check("post_rst_bc", byte_count, 0);
    check("post_rst_ovf", overflow, 0);
    check("post_rst_err", pkt_err, 0);
    check("post_rst_w_ovf", w_overflow, 0);
    @(posedge clk); #1;

    // Stray byte outside a packet, then an 8-byte packet.
    send_byte(8'hEE, 1'b0, 1'b0);
    send_seq(8'h01, 8, 1'b1);
    wait_idle();
    $display("[TB] 8-byte packet done");

    // 5-byte packet; the wrap instance's overflow must clear on its sop.
    send_byte(8'hA0, 1'b1, 1'b0);
    @(negedge clk);
    check("ovf_clr_on_sop", w_overflow, 0);
    @(posedge clk); #1;
    for (int i = 1; i < 5; i++) send_byte(8'hA0 + 8'(i), 1'b0, i == 4);
    wait_idle();
    $display("[TB] 5-byte packet done");

    // First write stalled by waitrequest for 3 cycles.
    stall_cnt = 0; wr_cnt = 0;
    m_waitrequest = 1'b1;
    fork
      send_seq(8'h10, 8, 1'b1);
      begin
        bit seen = 0;
        for (int k = 0; k < 100 && !seen; k++) begin
          @(posedge clk); #1;
          if (m_write) seen = 1;
        end
        check("stall_seen", seen, 1);
        repeat (3) @(posedge clk);
        #1 m_waitrequest = 1'b0;
      end
    join
    wait_idle();
    check("stall_cycles", stall_cnt, 3);
    check("stall_writes", wr_cnt, 2);
    $display("[TB] stalled packet done");

    // Restart mid-packet.
    send_seq(8'h30, 2, 1'b0);
    send_seq(8'h40, 4, 1'b1);
    wait_idle();
    $display("[TB] restarted packet done");

    // Single-byte packet.
    send_byte(8'h77, 1'b1, 1'b1);
    wait_idle();
    $display("[TB] single-byte packet done");

    // Reset while a write is stalled.
    m_waitrequest = 1'b1;
    send_seq(8'h50, 4, 1'b1);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    check("rst_wr_drop", m_write, 0);
    check("rst_wr_ready", st_ready, 0);
    check("rst_wr_done", done, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    m_waitrequest = 1'b0;
    @(negedge clk);
    check("rst_after_ready", st_ready, 1);
    check("rst_after_write", m_write, 0);
    check("rst_after_done", done, 0);
    @(posedge clk); #1;
    send_seq(8'h60, 6, 1'b1);
    wait_idle();
    $display("[TB] packet after reset done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
